// File: rtl/mult_seq_arbiter_if.sv
// rtl/mult_seq_arbiter_if.sv - request/response handshake and datapath strobe bundle for mult_seq_arbiter
interface mult_seq_arbiter_if;
  logic [1:0] Req_Valid;
  logic [1:0] Req_Ready;
  logic [1:0] Grant;
  logic       Sel;
  logic       M;
  logic       Ld_Operands;
  logic       Clr_XA;
  logic       Add;
  logic       Sub;
  logic       Shift;
  logic       Busy;
  logic [1:0] Rsp_Valid;
  logic [1:0] Rsp_Ready;

  // Sequencer side
  modport slave (
    input  Req_Valid, M, Rsp_Ready,
    output Req_Ready, Grant, Sel, Ld_Operands, Clr_XA, Add, Sub, Shift, Busy, Rsp_Valid
  );

  // Requester / datapath side
  modport master (
    output Req_Valid, M, Rsp_Ready,
    input  Req_Ready, Grant, Sel, Ld_Operands, Clr_XA, Add, Sub, Shift, Busy, Rsp_Valid
  );
endinterface

// File: rtl/mult_seq_arbiter.sv
// rtl/mult_seq_arbiter.sv - two-port arbiter and shift-add multiplier sequencer
module mult_seq_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  mult_seq_arbiter_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CLEAR = 3'd2,
    TEST  = 3'd3,
    ADD   = 3'd4,
    SUB   = 3'd5,
    SHIFT = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] iter, iter_nxt;
  logic          owner, owner_nxt;
  logic          last_served, last_served_nxt;

  logic [1:0]    owner_oh;
  logic          active;
  logic [1:0]    req_ready, grant, rsp_valid;
  logic          sel, ld, clr, add, sub, shift;

  // State, iteration counter and arbitration history registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      iter        <= '0;
      owner       <= 1'b0;
      last_served <= 1'b1;
    end else begin
      state       <= state_nxt;
      iter        <= iter_nxt;
      owner       <= owner_nxt;
      last_served <= last_served_nxt;
    end
  end

  // Next-state/arbitration decision and Moore output decode from state and owner
  always_comb begin
    state_nxt       = state;
    iter_nxt        = iter;
    owner_nxt       = owner;
    last_served_nxt = last_served;
    active          = 1'b0;
    ld              = 1'b0;
    clr             = 1'b0;
    add             = 1'b0;
    sub             = 1'b0;
    shift           = 1'b0;
    owner_oh        = owner ? 2'b10 : 2'b01;

    case (state)
      IDLE: begin
        if (bus.Req_Valid != 2'b00) begin
          // Contention goes to whoever was not served last
          case (bus.Req_Valid)
            2'b01:   owner_nxt = 1'b0;
            2'b10:   owner_nxt = 1'b1;
            default: owner_nxt = ~last_served;
          endcase
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        active    = 1'b1;
        ld        = 1'b1;
        iter_nxt  = '0;
        state_nxt = CLEAR;
      end
      CLEAR: begin
        active    = 1'b1;
        clr       = 1'b1;
        state_nxt = TEST;
      end
      TEST: begin
        active = 1'b1;
        if (bus.M) begin
          // The sign bit of a two's-complement multiplier carries negative weight
          state_nxt = (iter == LAST) ? SUB : ADD;
        end else begin
          state_nxt = SHIFT;
        end
      end
      ADD: begin
        active    = 1'b1;
        add       = 1'b1;
        state_nxt = SHIFT;
      end
      SUB: begin
        active    = 1'b1;
        sub       = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        active = 1'b1;
        shift  = 1'b1;
        if (iter == LAST) begin
          state_nxt = DONE;
        end else begin
          iter_nxt  = iter + CW'(1);
          state_nxt = TEST;
        end
      end
      DONE: begin
        active = 1'b1;
        if (bus.Rsp_Ready[owner]) begin
          last_served_nxt = owner;
          state_nxt       = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    grant     = active ? owner_oh : 2'b00;
    sel       = active & owner;
    req_ready = (state == LOAD) ? owner_oh : 2'b00;
    rsp_valid = (state == DONE) ? owner_oh : 2'b00;
  end

  assign bus.Req_Ready   = req_ready;
  assign bus.Grant       = grant;
  assign bus.Sel         = sel;
  assign bus.Ld_Operands = ld;
  assign bus.Clr_XA      = clr;
  assign bus.Add         = add;
  assign bus.Sub         = sub;
  assign bus.Shift       = shift;
  assign bus.Busy        = active;
  assign bus.Rsp_Valid   = rsp_valid;

endmodule

// File: tb/tb_mult_seq_arbiter.sv
// tb/tb_mult_seq_arbiter.sv - self-checking bench for mult_seq_arbiter with a queue-based step model
module tb_mult_seq_arbiter;
  localparam int WIDTH = 8;

  logic Clk;
  logic Reset_n;
  mult_seq_arbiter_if bus();

  mult_seq_arbiter #(.WIDTH(WIDTH)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the remaining steps of the current operation as a queue
  typedef enum {K_LOAD, K_CLEAR, K_TEST, K_ADD, K_SUB, K_SHIFT, K_DONE} step_t;
  step_t q[$];
  logic  m_owner = 1'b0;
  logic  m_last  = 1'b1;
  int    m_bits  = 0;

  always @(posedge Clk or negedge Reset_n) begin
    step_t cur;
    if (!Reset_n) begin
      q.delete();
      m_owner = 1'b0;
      m_last  = 1'b1;
      m_bits  = 0;
    end else if (q.size() == 0) begin
      if (bus.Req_Valid != 2'b00) begin
        m_owner = (bus.Req_Valid == 2'b11) ? ~m_last : bus.Req_Valid[1];
        q.push_back(K_LOAD);
      end
    end else begin
      cur = q.pop_front();
      case (cur)
        K_LOAD:  begin m_bits = 0; q.push_back(K_CLEAR); end
        K_CLEAR: q.push_back(K_TEST);
        K_TEST: begin
          if (bus.M) q.push_back((m_bits == WIDTH - 1) ? K_SUB : K_ADD);
          q.push_back(K_SHIFT);
        end
        K_SHIFT: begin
          m_bits++;
          q.push_back((m_bits == WIDTH) ? K_DONE : K_TEST);
        end
        K_DONE: begin
          if (bus.Rsp_Ready[m_owner]) m_last = m_owner;
          else q.push_back(K_DONE);
        end
        default: ;
      endcase
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge Clk) begin
    logic [7:0] eh, ah;
    logic [4:0] es, as_;
    logic [1:0] g;
    eh = '0;
    es = '0;
    if (Reset_n === 1'b1 && q.size() != 0) begin
      g  = m_owner ? 2'b10 : 2'b01;
      eh = {(q[0] == K_LOAD) ? g : 2'b00, g, m_owner, 1'b1, (q[0] == K_DONE) ? g : 2'b00};
      es = {q[0] == K_LOAD, q[0] == K_CLEAR, q[0] == K_ADD, q[0] == K_SUB, q[0] == K_SHIFT};
    end
    if (Reset_n !== 1'bx) begin
      ah  = {bus.Req_Ready, bus.Grant, bus.Sel, bus.Busy, bus.Rsp_Valid};
      as_ = {bus.Ld_Operands, bus.Clr_XA, bus.Add, bus.Sub, bus.Shift};
      chk("cyc_handshake", 32'(ah), 32'(eh));
      chk("cyc_strobes", 32'(as_), 32'(es));
      chk("strobe_exclusive", 32'($countones(as_) <= 1), 32'd1);
    end
  end

  function automatic logic [12:0] outs();
    outs = {bus.Req_Ready, bus.Grant, bus.Sel, bus.Ld_Operands, bus.Clr_XA,
            bus.Add, bus.Sub, bus.Shift, bus.Busy, bus.Rsp_Valid};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (bus.Busy && c < 200) begin
      bus.M = 1'($urandom);
      tick();
      c++;
    end
    chk(name, 32'(bus.Busy), 32'd0);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    tick();
    tick();
    Reset_n = 1'b1;
  endtask

  // One operation from IDLE with a constant M; returns the cycle of first DONE relative to LOAD
  task automatic run_op(input logic [1:0] rv, input logic mv, output int lat,
                        output int na, output int ns, output int nsh, output logic [1:0] g);
    int c;
    bus.Req_Valid = rv;
    bus.M = mv;
    tick();
    g = bus.Grant;
    chk("op_load_strobe", 32'(bus.Ld_Operands), 32'd1);
    bus.Req_Valid = 2'b00;
    na = 0; ns = 0; nsh = 0; c = 0;
    while (bus.Rsp_Valid == 2'b00 && c < 100) begin
      tick();
      c++;
      if (bus.Add) na++;
      if (bus.Sub) ns++;
      if (bus.Shift) nsh++;
    end
    lat = c;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, na, ns, nsh, c, sh;
    logic [1:0] g, rr, pend;
    logic [1:0] t4_exp [4];
    t4_exp = '{2'b01, 2'b10, 2'b01, 2'b10};

    bus.Req_Valid = 2'b00;
    bus.M         = 1'b0;
    bus.Rsp_Ready = 2'b00;
    Reset_n       = 1'b1;
    #1 Reset_n    = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_outputs", 32'(outs()), 32'd0);
    Reset_n = 1'b1;
    tick();

    // T1: reset during SHIFT of iteration 3
    bus.Req_Valid = 2'b01;
    bus.M = 1'b0;
    tick();
    bus.Req_Valid = 2'b00;
    sh = 0; c = 0;
    while (sh < 4 && c < 50) begin
      tick();
      c++;
      if (bus.Shift) sh++;
    end
    chk("t1_in_shift", 32'(bus.Shift), 32'd1);
    Reset_n = 1'b0;
    #1;
    chk("t1_async_zero", 32'(outs()), 32'd0);
    tick();
    chk("t1_held_zero", 32'(outs()), 32'd0);
    Reset_n = 1'b1;
    bus.Req_Valid = 2'b01;
    tick();
    chk("t1_grant_after", 32'(bus.Grant), 32'h1);
    bus.Req_Valid = 2'b00;
    bus.Rsp_Ready = 2'b01;
    wait_idle("t1_idle");

    // T2: zero multiplier
    run_op(2'b01, 1'b0, lat, na, ns, nsh, g);
    chk("t2_grant", 32'(g), 32'h1);
    chk("t2_latency", 32'(lat), 32'd18);
    chk("t2_adds", 32'(na), 32'd0);
    chk("t2_subs", 32'(ns), 32'd0);
    chk("t2_shifts", 32'(nsh), 32'd8);
    chk("t2_rsp_valid", 32'(bus.Rsp_Valid), 32'h1);
    tick();
    chk("t2_done_one_cycle", 32'(bus.Busy), 32'd0);

    // T3: all ones multiplier
    run_op(2'b01, 1'b1, lat, na, ns, nsh, g);
    chk("t3_latency", 32'(lat), 32'd26);
    chk("t3_adds", 32'(na), 32'd7);
    chk("t3_subs", 32'(ns), 32'd1);
    chk("t3_shifts", 32'(nsh), 32'd8);
    tick();
    chk("t3_idle", 32'(bus.Busy), 32'd0);

    // T4: alternating fairness under continuous contention
    do_reset();
    bus.Req_Valid = 2'b11;
    bus.Rsp_Ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      c = 0;
      while (!bus.Ld_Operands && c < 100) begin
        bus.M = 1'($urandom);
        tick();
        c++;
      end
      chk("t4_grant", 32'(bus.Grant), 32'(t4_exp[k]));
      chk("t4_sel", 32'(bus.Sel), 32'(k % 2));
      chk("t4_req_ready", 32'(bus.Req_Ready), 32'(t4_exp[k]));
      tick();
    end
    bus.Req_Valid = 2'b00;
    wait_idle("t4_idle");

    // T5/T6: response backpressure with a competing request and stray ready
    bus.Rsp_Ready = 2'b00;
    bus.Req_Valid = 2'b01;
    tick();
    chk("t5_grant0", 32'(bus.Grant), 32'h1);
    bus.Req_Valid = 2'b10;
    c = 0;
    while (bus.Rsp_Valid == 2'b00 && c < 100) begin
      bus.M = 1'($urandom);
      tick();
      c++;
    end
    for (int d = 0; d < 5; d++) begin
      bus.Rsp_Ready = (d >= 2) ? 2'b10 : 2'b00;
      chk("t5_rsp_held", 32'(bus.Rsp_Valid), 32'h1);
      chk("t5_grant_held", 32'(bus.Grant), 32'h1);
      chk("t5_busy_held", 32'(bus.Busy), 32'd1);
      tick();
    end
    chk("t6_stray_ready", 32'(bus.Rsp_Valid), 32'h1);
    bus.Rsp_Ready = 2'b01;
    tick();
    chk("t5_idle_gap", 32'(bus.Busy), 32'd0);
    tick();
    chk("t5_grant1", 32'(bus.Grant), 32'h2);
    chk("t5_sel1", 32'(bus.Sel), 32'd1);
    bus.Req_Valid = 2'b00;
    bus.Rsp_Ready = 2'b11;
    wait_idle("t5_finish");

    // Randomized traffic checked by the per-cycle model compare
    pend = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 7) == 0) pend[r] = 1'b1;
      end
      bus.Req_Valid = pend;
      bus.M         = 1'($urandom);
      bus.Rsp_Ready = 2'($urandom_range(0, 3));
      Reset_n       = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      #1;
      rr = bus.Req_Ready;
      tick();
      pend = pend & ~rr;
    end
    Reset_n = 1'b1;
    bus.Req_Valid = 2'b00;
    bus.Rsp_Ready = 2'b11;
    wait_idle("final_idle");
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
